// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_pkg
//  Description : Shared constants, state encoding and address packing for the
//                VGA text writer.
//                Cell address : {19'b0, row[4:0], col[5:0], 2'b00}
//                Cell word    : {color[2:0], 8'h00, code[7:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

    localparam int COLS = 40;
    localparam int ROWS = 30;

    localparam logic [5:0] COL_LAST = 6'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    // Space character in colour 000; what every clear writes.
    localparam logic [18:0] BLANK_WORD = 19'h00020;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_CLR_LINE   = 2'd2,
        ST_CLR_SCREEN = 2'd3
    } state_t;

    // Byte address of a cell; the display side decodes the same layout.
    function automatic logic [31:0] pack_addr(input logic [4:0] row, input logic [5:0] col);
        return {19'b0, row, col, 2'b00};
    endfunction

    // Row after a newline; the screen wraps instead of scrolling.
    function automatic logic [4:0] next_row(input logic [4:0] row);
        return (row == ROW_LAST) ? 5'd0 : row + 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_writer_if
//  Description : Character input stream and VRAM write port of the text
//                writer bundled as one interface.
//                  ch_valid/ch_data/ch_color/ch_ready : character stream
//                  vram_we/vram_wr_rdy                : write request/accept
//                  vram_addr/vram_wdata               : write address/cell word
//                modport slave  : view of the text writer itself
//                modport master : view of the environment (source + VRAM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_text_writer_if;

    logic        ch_valid;
    logic [7:0]  ch_data;
    logic [2:0]  ch_color;
    logic        ch_ready;

    logic        vram_we;
    logic        vram_wr_rdy;
    logic [31:0] vram_addr;
    logic [18:0] vram_wdata;

    modport slave (
        input  ch_valid, ch_data, ch_color, vram_wr_rdy,
        output ch_ready, vram_we, vram_addr, vram_wdata
    );

    modport master (
        output ch_valid, ch_data, ch_color, vram_wr_rdy,
        input  ch_ready, vram_we, vram_addr, vram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/vga_clear_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : vga_clear_sweep
//  Description : Row/column sweep counter used to walk cells during a line or
//                full-screen clear.
//                  start     : load position; row = start_row (line mode) or 0
//                  full      : sampled with start; 1 = whole screen, 0 = one row
//                  advance   : current cell was accepted, move to the next one
//                  row/col   : cell currently being addressed
//                  done      : final cell accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_clear_sweep
    import vga_text_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       full,
    input  logic [4:0] start_row,
    input  logic       advance,
    output logic [4:0] row,
    output logic [5:0] col,
    output logic       done
);

    logic [4:0] r_row;
    logic [5:0] r_col;
    logic       r_full;
    logic       r_active;
    logic       w_last;

    // Line mode ends at the last column; screen mode also needs the last row.
    assign w_last = (r_col == COL_LAST) && (!r_full || (r_row == ROW_LAST));
    assign done   = r_active & advance & w_last;
    assign row    = r_row;
    assign col    = r_col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row    <= 5'd0;
            r_col    <= 6'd0;
            r_full   <= 1'b0;
            r_active <= 1'b0;
        end else if (start) begin
            r_row    <= full ? 5'd0 : start_row;
            r_col    <= 6'd0;
            r_full   <= full;
            r_active <= 1'b1;
        end else if (r_active && advance) begin
            if (w_last) begin
                r_active <= 1'b0;
            end else if (r_col == COL_LAST) begin
                r_col <= 6'd0;
                r_row <= next_row(r_row);
            end else begin
                r_col <= r_col + 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_text_writer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_writer
//  Description : Turns a stream of character codes into VRAM cell writes and
//                tracks a hardware cursor. Handles printable codes, CR, LF,
//                BS and FF (full clear), line wrap and screen wrap.
//  Ports       : clk, reset (async, active high)
//                bus        : vga_text_writer_if.slave (char stream + VRAM port)
//                cursor_row : current cursor row    0..ROWS-1
//                cursor_col : current cursor column 0..COLS-1
//                busy       : high whenever not idle
//  Config      : `define VGA_TEXT_CLEAR_LINE_EN to blank the new row on
//                every newline (LF or wrap past the last column).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_writer
    import vga_text_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    vga_text_writer_if.slave   bus,
    output logic [4:0]         cursor_row,
    output logic [5:0]         cursor_col,
    output logic               busy
);

    state_t      r_state,  w_state_nxt;
    logic [4:0]  r_row,    w_row_nxt;
    logic [5:0]  r_col,    w_col_nxt;
    logic        r_we,     w_we_nxt;
    logic [31:0] r_addr,   w_addr_nxt;
    logic [18:0] r_wdata,  w_wdata_nxt;
    logic        r_adv,    w_adv_nxt;   // advance cursor after this single write

    logic        w_wr_fire;
    logic        w_clearing;
    logic        w_sw_start;
    logic        w_sw_full;
    logic [4:0]  w_sw_row;
    logic [4:0]  w_sw_cur_row;
    logic [5:0]  w_sw_cur_col;
    logic        w_sw_done;

    assign w_wr_fire  = r_we & bus.vram_wr_rdy;
    assign w_clearing = (r_state == ST_CLR_LINE) || (r_state == ST_CLR_SCREEN);

    vga_clear_sweep u_sweep (
        .clk       (clk),
        .reset     (reset),
        .start     (w_sw_start),
        .full      (w_sw_full),
        .start_row (w_sw_row),
        .advance   (w_wr_fire & w_clearing),
        .row       (w_sw_cur_row),
        .col       (w_sw_cur_col),
        .done      (w_sw_done)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_row   <= 5'd0;
            r_col   <= 6'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 19'd0;
            r_adv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_adv   <= w_adv_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_adv_nxt   = r_adv;
        w_sw_start  = 1'b0;
        w_sw_full   = 1'b0;
        w_sw_row    = next_row(r_row);

        case (r_state)
            ST_IDLE: begin
                if (bus.ch_valid) begin
                    case (bus.ch_data)
                        CH_LF: begin
                            w_col_nxt = 6'd0;
                            w_row_nxt = next_row(r_row);
`ifdef VGA_TEXT_CLEAR_LINE_EN
                            w_sw_start  = 1'b1;
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = BLANK_WORD;
                            w_state_nxt = ST_CLR_LINE;
`endif
                        end
                        CH_CR: begin
                            w_col_nxt = 6'd0;
                        end
                        CH_BS: begin
                            // Erase the cell the cursor steps back onto.
                            if (r_col != 6'd0) begin
                                w_col_nxt   = r_col - 6'd1;
                                w_addr_nxt  = pack_addr(r_row, r_col - 6'd1);
                                w_wdata_nxt = BLANK_WORD;
                                w_we_nxt    = 1'b1;
                                w_adv_nxt   = 1'b0;
                                w_state_nxt = ST_WRITE;
                            end
                        end
                        CH_FF: begin
                            w_sw_start  = 1'b1;
                            w_sw_full   = 1'b1;
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = BLANK_WORD;
                            w_state_nxt = ST_CLR_SCREEN;
                        end
                        default: begin
                            w_addr_nxt  = pack_addr(r_row, r_col);
                            w_wdata_nxt = {bus.ch_color, 8'h00, bus.ch_data};
                            w_we_nxt    = 1'b1;
                            w_adv_nxt   = 1'b1;
                            w_state_nxt = ST_WRITE;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                if (w_wr_fire) begin
                    w_we_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (r_adv) begin
                        if (r_col != COL_LAST) begin
                            w_col_nxt = r_col + 6'd1;
                        end else begin
                            w_col_nxt = 6'd0;
                            w_row_nxt = next_row(r_row);
`ifdef VGA_TEXT_CLEAR_LINE_EN
                            w_sw_start  = 1'b1;
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = BLANK_WORD;
                            w_state_nxt = ST_CLR_LINE;
`endif
                        end
                    end
                end
            end

            ST_CLR_LINE, ST_CLR_SCREEN: begin
                if (w_sw_done) begin
                    w_we_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (r_state == ST_CLR_SCREEN) begin
                        w_row_nxt = 5'd0;
                        w_col_nxt = 6'd0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: during clears the address follows the sweep counter, which
    // only moves on an accepted write, so it stays stable while stalled.
    // ------------------------------------------------------------------
    assign bus.ch_ready   = (r_state == ST_IDLE);
    assign bus.vram_we    = r_we;
    assign bus.vram_addr  = w_clearing ? pack_addr(w_sw_cur_row, w_sw_cur_col) : r_addr;
    assign bus.vram_wdata = r_wdata;
    assign cursor_row     = r_row;
    assign cursor_col     = r_col;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
